mic_frame_aligner: RTL
======================

# mic_frame_aligner

Downstream of the per-microphone I2S decoders in the acoustic-camera audio path. Collects one left-channel sample from each of NUM_MIC decoders, each marked by that decoder's single-cycle `recv_over` pulse, into a time-aligned frame. Serialises the frame as a valid/ready stream toward the beamforming/FFT stage. Detects missing and duplicated samples. A pending bank absorbs the next frame while the current one drains.

## Interface
- `NUM_MIC`, 8: number of microphones/decoders; ≥2.
- `DATAWIDTH`, 24: sample width, two's complement, matches the decoder output.
- `TIMEOUT`, 48: cycles allowed from a bank becoming active to all channels captured; ≥NUM_MIC.
- `CHAN_W`, $clog2(NUM_MIC): channel index width (derived).

Ports:
- `clk_mic` in 1: microphone bit clock, 64·fs; the only clock.
- `rst_mic` in 1: reset, synchronous, active-high.
- `mic_data` in NUM_MIC·DATAWIDTH: decoder samples; channel i at bits [i·DATAWIDTH +: DATAWIDTH].
- `mic_valid` in NUM_MIC: decoder `recv_over` pulses; bit i qualifies channel i this cycle.
- `out_data` out DATAWIDTH: signed sample of current channel.
- `out_chan` out CHAN_W: channel index of `out_data`.
- `out_last` out 1: high with channel NUM_MIC-1.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: downstream ready.
- `frame_cnt` out 16: count of completed frames; wraps.
- `err_timeout` out 1: one-cycle pulse when a frame is closed with zero-filled channels.
- `err_overrun` out 1: one-cycle pulse when a sample is dropped.

## Operation
- Two banks, ACTIVE and PENDING. Each bank holds NUM_MIC samples plus a capture mask. States: IDLE, COLLECT, DRAIN.
- IDLE, mask empty, timer 0. Any `mic_valid` bit captures those channels and moves to COLLECT. If all bits are set in one cycle, go directly to DRAIN.
- COLLECT:
  - Each cycle, capture channel i if `mic_valid[i]` and mask bit i is clear.
  - `mic_valid[i]` with mask bit i already set: first sample kept, new one dropped, `err_overrun` pulses.
  - Timer increments each COLLECT cycle.
  - Mask full, including captures on this edge: go to DRAIN.
  - Timer == TIMEOUT-1 with mask not full: uncaptured channels forced to 0, `err_timeout` pulses, go to DRAIN.
  - Full and timeout on the same edge: full wins, no error.
- DRAIN:
  - Emit channels 0..NUM_MIC-1 in ascending order, advancing on `out_valid && out_ready`.
  - `mic_valid` pulses write to PENDING under the same capture/overrun rules. The PENDING timer does not run.
  - On the accepted handshake of `out_last`: `frame_cnt`+1, PENDING swaps to ACTIVE, PENDING is cleared, timer resets to 0.
  - Next state after the swap: DRAIN if the swapped mask is full; COLLECT if it is non-empty; otherwise IDLE.
  - A `mic_valid` on the swap edge goes to the new ACTIVE bank.
- `frame_cnt` wraps 0xFFFF→0.
- Reset at any point clears both banks, masks, timer, counters and state; in-flight frame is discarded.

## Timing
- Reset values:
  - `out_data`=0, `out_chan`=0, `out_last`=0, `out_valid`=0
  - `frame_cnt`=0, `err_timeout`=0, `err_overrun`=0
- Latency: edge capturing the final channel (or the timeout edge) → `out_valid`=1 with channel 0 in the next cycle.
- Drain throughput is 1 channel/cycle with `out_ready` held high, i.e. NUM_MIC cycles per frame.
- While `out_valid && !out_ready`, `out_data`/`out_chan`/`out_last` hold stable. `out_valid` never deasserts without a handshake.
- `out_valid` is 0 in IDLE and COLLECT.
- Error pulses are registered and appear in the cycle after the causing edge.

## Structure
- Shared package `mic_array_pkg`: NUM_MIC, DATAWIDTH, CHAN_W, state encoding constants (IDLE/COLLECT/DRAIN).
- Sub-module `mic_sample_bank`: NUM_MIC sample registers plus mask. Inputs: capture vector, data, clear, force-zero-fill. Outputs: mask-full, overrun vector, read-mux by index. Instantiated twice, with swap done by a bank-select bit rather than copying.

## Test plan
- Staggered arrival: channels 0..7 pulse on consecutive cycles with data 0x000100+i, `out_ready`=1 → 8 beats, chan 0..7, data matches, `out_last` on chan 7, `frame_cnt`=1, no errors.
- Timeout: channels 0..5 only, then silence → `err_timeout` pulse once, frame emitted with chans 6,7 = 0, `frame_cnt`=1.
- Overrun: channel 3 pulses twice (0x111111 then 0x222222) before frame full → `err_overrun` pulse; emitted chan 3 = 0x111111.
- Backpressure plus pending: `out_ready` low 20 cycles during DRAIN while a full second frame arrives → first frame data held stable. After release, second frame emits back-to-back with no gap; `frame_cnt`=2.
- Reset mid-DRAIN at beat 4 → next cycle all outputs 0, IDLE. A fresh frame then emits from chan 0 with `frame_cnt`=1.
- Sign/width: all channels 0x800000 and 0x7FFFFF alternately → values passed through unmodified; `frame_cnt` preset-wrap test 0xFFFF→0.

Source files
------------

// File: rtl/mic_array_pkg.sv
// rtl/mic_array_pkg.sv - shared constants and state encoding for the mic frame aligner
package mic_array_pkg;

    localparam int NUM_MIC   = 8;
    localparam int DATAWIDTH = 24;
    localparam int TIMEOUT   = 48;
    localparam int CHAN_W    = $clog2(NUM_MIC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/mic_sample_bank.sv
// rtl/mic_sample_bank.sv - one frame of per-channel samples with capture mask
module mic_sample_bank #(
    parameter int NUM_MIC   = 8,
    parameter int DATAWIDTH = 24,
    parameter int CHAN_W    = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           zero_fill_i,
    input  logic [NUM_MIC-1:0]             cap_i,
    input  logic [NUM_MIC*DATAWIDTH-1:0]   data_i,
    input  logic [CHAN_W-1:0]              rd_idx_i,
    output logic [DATAWIDTH-1:0]           rd_data_o,
    output logic                           full_o,
    output logic                           any_o,
    output logic [NUM_MIC-1:0]             ovr_o
);

    logic [NUM_MIC-1:0][DATAWIDTH-1:0] sample_q;
    logic [NUM_MIC-1:0]                mask_q;
    logic [NUM_MIC-1:0]                mask_d;
    logic [NUM_MIC-1:0]                take;

    // First sample per channel wins; full/any look ahead to include this edge's captures
    always_comb begin
        take   = cap_i & ~mask_q;
        ovr_o  = cap_i & mask_q;
        mask_d = mask_q | cap_i;
        full_o = &mask_d;
        any_o  = |mask_d;
    end

    // Sample and mask registers; zero fill closes the frame with missing channels at 0
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            mask_q   <= '0;
            sample_q <= '0;
        end else begin
            mask_q <= zero_fill_i ? '1 : mask_d;
            for (int i = 0; i < NUM_MIC; i++) begin
                if (take[i]) begin
                    sample_q[i] <= data_i[i*DATAWIDTH +: DATAWIDTH];
                end else if (zero_fill_i && !mask_q[i]) begin
                    sample_q[i] <= '0;
                end
            end
        end
    end

    assign rd_data_o = sample_q[rd_idx_i];

endmodule

// File: rtl/mic_frame_aligner.sv
// rtl/mic_frame_aligner.sv - aligns per-mic samples into frames and streams them out
module mic_frame_aligner #(
    parameter int   NUM_MIC   = mic_array_pkg::NUM_MIC,
    parameter int   DATAWIDTH = mic_array_pkg::DATAWIDTH,
    parameter int   TIMEOUT   = mic_array_pkg::TIMEOUT,
    localparam int  CHAN_W    = $clog2(NUM_MIC)
) (
    input  logic                          clk_mic,
    input  logic                          rst_mic,
    input  logic [NUM_MIC*DATAWIDTH-1:0]  mic_data,
    input  logic [NUM_MIC-1:0]            mic_valid,
    output logic [DATAWIDTH-1:0]          out_data,
    output logic [CHAN_W-1:0]             out_chan,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   frame_cnt,
    output logic                          err_timeout,
    output logic                          err_overrun
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    mic_array_pkg::state_e state_q, state_d;
    logic                  bank_sel_q, bank_sel_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [CHAN_W-1:0]     idx_q, idx_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_overrun_q, err_overrun_d;

    logic                  swap, zero_fill, wr_sel;
    logic                  wr_full, wr_any;
    logic [NUM_MIC-1:0]    wr_ovr;
    logic [NUM_MIC-1:0]    cap0, cap1, ovr0, ovr1;
    logic                  full0, full1, any0, any1;
    logic [DATAWIDTH-1:0]  rd0, rd1;

    // Captures go to the active bank while collecting, to the pending bank while draining
    always_comb begin
        wr_sel  = (state_q == mic_array_pkg::DRAIN) ? ~bank_sel_q : bank_sel_q;
        cap0    = wr_sel ? '0 : mic_valid;
        cap1    = wr_sel ? mic_valid : '0;
        wr_full = wr_sel ? full1 : full0;
        wr_any  = wr_sel ? any1 : any0;
        wr_ovr  = wr_sel ? ovr1 : ovr0;
    end

    mic_sample_bank #(.NUM_MIC(NUM_MIC), .DATAWIDTH(DATAWIDTH), .CHAN_W(CHAN_W)) u_bank0 (
        .clk_i       (clk_mic),
        .rst_i       (rst_mic),
        .clear_i     (swap && !bank_sel_q),
        .zero_fill_i (zero_fill && !bank_sel_q),
        .cap_i       (cap0),
        .data_i      (mic_data),
        .rd_idx_i    (idx_q),
        .rd_data_o   (rd0),
        .full_o      (full0),
        .any_o       (any0),
        .ovr_o       (ovr0)
    );

    mic_sample_bank #(.NUM_MIC(NUM_MIC), .DATAWIDTH(DATAWIDTH), .CHAN_W(CHAN_W)) u_bank1 (
        .clk_i       (clk_mic),
        .rst_i       (rst_mic),
        .clear_i     (swap && bank_sel_q),
        .zero_fill_i (zero_fill && bank_sel_q),
        .cap_i       (cap1),
        .data_i      (mic_data),
        .rd_idx_i    (idx_q),
        .rd_data_o   (rd1),
        .full_o      (full1),
        .any_o       (any1),
        .ovr_o       (ovr1)
    );

    // Next-state logic: collect until full or timed out, drain, then swap banks
    always_comb begin
        state_d       = state_q;
        bank_sel_d    = bank_sel_q;
        timer_d       = timer_q;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        swap          = 1'b0;
        zero_fill     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = |wr_ovr;
        case (state_q)
            mic_array_pkg::IDLE: begin
                timer_d = '0;
                if (wr_full) begin
                    state_d = mic_array_pkg::DRAIN;
                end else if (wr_any) begin
                    state_d = mic_array_pkg::COLLECT;
                end
            end
            mic_array_pkg::COLLECT: begin
                timer_d = timer_q + 1'b1;
                if (wr_full) begin
                    state_d = mic_array_pkg::DRAIN;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    zero_fill     = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = mic_array_pkg::DRAIN;
                    timer_d       = '0;
                end
            end
            mic_array_pkg::DRAIN: begin
                if (out_ready) begin
                    if (idx_q == CHAN_W'(NUM_MIC - 1)) begin
                        idx_d       = '0;
                        swap        = 1'b1;
                        bank_sel_d  = ~bank_sel_q;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        timer_d     = '0;
                        if (wr_full) begin
                            state_d = mic_array_pkg::DRAIN;
                        end else if (wr_any) begin
                            state_d = mic_array_pkg::COLLECT;
                        end else begin
                            state_d = mic_array_pkg::IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = mic_array_pkg::IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk_mic) begin
        if (rst_mic) begin
            state_q       <= mic_array_pkg::IDLE;
            bank_sel_q    <= 1'b0;
            timer_q       <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_sel_q    <= bank_sel_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign out_valid   = (state_q == mic_array_pkg::DRAIN);
    assign out_chan    = idx_q;
    assign out_last    = out_valid && (idx_q == CHAN_W'(NUM_MIC - 1));
    assign out_data    = out_valid ? (bank_sel_q ? rd1 : rd0) : '0;
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule
